// File: rtl/add_serial_pkg.sv
// Shared types and default sizing for the digit-serial adder/subtractor.
package add_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DIGIT = 1;

endpackage

// File: rtl/serial_digit_adder.sv
// Combinational DIGIT-bit slice adder; cmsb is the carry into the slice MSB.
// ADD_SERIAL_OVF_EN selects the split adder that exposes cmsb, otherwise cmsb is 0.
module serial_digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             cmsb
);

`ifdef ADD_SERIAL_OVF_EN
    if (DIGIT == 1) begin : g_one
        assign cmsb = cin;
        assign s    = a ^ b ^ cin;
        assign cout = (a[0] & b[0]) | (a[0] & cin) | (b[0] & cin);
    end else begin : g_split
        // Low DIGIT-1 bits first so the carry into the MSB is visible.
        logic [DIGIT-1:0] lo;
        assign lo   = {1'b0, a[DIGIT-2:0]} + {1'b0, b[DIGIT-2:0]} + {{(DIGIT-1){1'b0}}, cin};
        assign cmsb = lo[DIGIT-1];
        assign s    = {a[DIGIT-1] ^ b[DIGIT-1] ^ cmsb, lo[DIGIT-2:0]};
        assign cout = (a[DIGIT-1] & b[DIGIT-1]) | (a[DIGIT-1] & cmsb) | (b[DIGIT-1] & cmsb);
    end
`else
    logic [DIGIT:0] sum;
    assign sum  = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
    assign s    = sum[DIGIT-1:0];
    assign cout = sum[DIGIT];
    assign cmsb = 1'b0;
`endif

endmodule

// File: rtl/add_sub_serial_param.sv
// Digit-serial WIDTH-bit adder/subtractor, LSD first, valid/ready on both sides.
// Optional signed overflow output enabled by ADD_SERIAL_OVF_EN.
//
// state | meaning
// IDLE  | waiting for operands, in_ready = 1
// ADD   | one DIGIT slice per cycle, N cycles
// DONE  | result presented, waiting for out_ready
module add_sub_serial_param
    import add_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIGIT = DEFAULT_DIGIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("add_sub_serial_param: WIDTH must be a multiple of DIGIT");
    end
    if (WIDTH < 2) begin : g_bad_width
        $error("add_sub_serial_param: WIDTH must be at least 2");
    end

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] out_next;
    logic [CW-1:0]    count;
    logic             carry;
    logic             carry_out_reg;
    logic [DIGIT-1:0] d_s;
    logic             d_cout;
    logic             d_cmsb;
    logic             accept;
    logic             last_digit;

    serial_digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a    (a_reg[DIGIT-1:0]),
        .b    (b_reg[DIGIT-1:0]),
        .cin  (carry),
        .s    (d_s),
        .cout (d_cout),
        .cmsb (d_cmsb)
    );

    // New digit enters at the MSB; after N shifts the result is aligned.
    if (N == 1) begin : g_single
        assign out_next = d_s;
    end else begin : g_multi
        assign out_next = {d_s, out_reg[WIDTH-1:DIGIT]};
    end

    assign accept     = in_valid && (state == IDLE);
    assign last_digit = (state == ADD) && (count == LAST);
    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign out        = out_reg;
    assign carry_out  = carry_out_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            out_reg       <= '0;
            count         <= '0;
            carry         <= 1'b0;
            carry_out_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg         <= a;
                        b_reg         <= sub ? ~b : b;
                        carry         <= sub;
                        out_reg       <= '0;
                        count         <= '0;
                        carry_out_reg <= 1'b0;
                        state         <= ADD;
                    end
                end
                ADD: begin
                    out_reg <= out_next;
                    a_reg   <= a_reg >> DIGIT;
                    b_reg   <= b_reg >> DIGIT;
                    carry   <= d_cout;
                    count   <= count + CW'(1);
                    if (last_digit) begin
                        carry_out_reg <= d_cout;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADD_SERIAL_OVF_EN
    logic ovf_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (accept) begin
            ovf_reg <= 1'b0;
        end else if (last_digit) begin
            ovf_reg <= d_cmsb ^ d_cout;
        end
    end

    assign overflow = ovf_reg;
`else
    // The slice adder drives cmsb low in this build, so overflow is constant 0.
    assign overflow = d_cmsb;
`endif

endmodule

// File: tb/tb_add_sub_serial_param.sv
// Bench for add_sub_serial_param: 8/1 and 16/4 instances, directed vectors
// against an arithmetic model checked every cycle.
module tb_add_sub_serial_param;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv8, rdy8, sub8, ov8, ordy8, co8, vf8;
    logic [7:0]  a8, b8, out8;
    logic        iv16, rdy16, sub16, ov16, ordy16, co16, vf16;
    logic [15:0] a16, b16, out16;

    int checks = 0;
    int errors = 0;

    add_sub_serial_param #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8), .a(a8), .b(b8),
        .sub(sub8), .out_valid(ov8), .out_ready(ordy8), .out(out8),
        .carry_out(co8), .overflow(vf8)
    );

    add_sub_serial_param #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(rdy16), .a(a16), .b(b16),
        .sub(sub16), .out_valid(ov16), .out_ready(ordy16), .out(out16),
        .carry_out(co16), .overflow(vf16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result from plain integer arithmetic with signed range test for overflow.
    function automatic void model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                  input logic s, output logic [31:0] r, output logic c,
                                  output logic v);
        longint ua, ub, sa, sb, sr, m;
        m  = longint'(1) << w;
        ua = longint'(av);
        ub = longint'(bv);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (s) begin
            r  = 32'((ua - ub + m) % m);
            c  = (ua >= ub);
            sr = sa - sb;
        end else begin
            r  = 32'((ua + ub) % m);
            c  = (ua + ub >= m);
            sr = sa + sb;
        end
`ifdef ADD_SERIAL_OVF_EN
        v = (sr < -(m / 2)) || (sr > m / 2 - 1);
`else
        v = 1'b0;
`endif
    endfunction

    // Per-cycle compare: phase 0 idle, 1 busy, 2 result presented.
    int          phase [2] = '{0, 0};
    int          cnt   [2] = '{0, 0};
    logic        have  [2] = '{1'b0, 1'b0};
    logic [31:0] er    [2];
    logic        ec    [2];
    logic        ev    [2];
    int          wid   [2] = '{8, 16};
    int          ndig  [2] = '{8, 4};

    always @(negedge clk) begin
        logic ir, ovv, co, vf, iv, ordy, sb;
        logic [31:0] o, av, bv;
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                ir = rdy8; ovv = ov8; co = co8; vf = vf8; o = 32'(out8);
                iv = iv8; ordy = ordy8; av = 32'(a8); bv = 32'(b8); sb = sub8;
            end else begin
                ir = rdy16; ovv = ov16; co = co16; vf = vf16; o = 32'(out16);
                iv = iv16; ordy = ordy16; av = 32'(a16); bv = 32'(b16); sb = sub16;
            end
            if (rst) begin
                phase[d] = 0;
                have[d]  = 1'b0;
            end
            check($sformatf("in_ready[%0d]", d), 32'(ir), 32'(phase[d] == 0));
            check($sformatf("out_valid[%0d]", d), 32'(ovv), 32'(phase[d] == 2));
            if (phase[d] != 1) begin
                check($sformatf("out[%0d]", d), o, have[d] ? er[d] : 32'd0);
                check($sformatf("carry_out[%0d]", d), 32'(co), have[d] ? 32'(ec[d]) : 32'd0);
                check($sformatf("overflow[%0d]", d), 32'(vf), have[d] ? 32'(ev[d]) : 32'd0);
            end
            if (!rst) begin
                case (phase[d])
                    0: if (iv) begin
                        model(wid[d], av, bv, sb, er[d], ec[d], ev[d]);
                        have[d]  = 1'b1;
                        cnt[d]   = 0;
                        phase[d] = 1;
                    end
                    1: begin
                        cnt[d]++;
                        if (cnt[d] == ndig[d]) phase[d] = 2;
                    end
                    default: if (ordy) phase[d] = 0;
                endcase
            end
        end
    end

    task automatic drive(input int d, input logic iv, input logic [31:0] av,
                         input logic [31:0] bv, input logic s);
        if (d == 0) begin
            iv8 = iv; a8 = av[7:0]; b8 = bv[7:0]; sub8 = s;
        end else begin
            iv16 = iv; a16 = av[15:0]; b16 = bv[15:0]; sub16 = s;
        end
    endtask

    function automatic logic ovalid(input int d);
        return (d == 0) ? ov8 : ov16;
    endfunction

    function automatic logic irdy(input int d);
        return (d == 0) ? rdy8 : rdy16;
    endfunction

    task automatic op(input int d, input logic [31:0] av, input logic [31:0] bv, input logic s,
                      output logic [31:0] r, output logic c, output logic v, output int lat);
        int guard = 0;
        while (!irdy(d) && guard < 40) begin
            @(posedge clk); #1; guard++;
        end
        drive(d, 1'b1, av, bv, s);
        @(posedge clk); #1;
        drive(d, 1'b0, av, bv, s);
        lat = 0;
        while (!ovalid(d) && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        if (!ovalid(d)) begin
            checks++;
            errors++;
            $display("FAIL timeout[%0d]: out_valid got 0 expected 1 within 40 cycles", d);
        end
        r = (d == 0) ? 32'(out8) : 32'(out16);
        c = (d == 0) ? co8 : co16;
        v = (d == 0) ? vf8 : vf16;
    endtask

    logic [31:0] r;
    logic c, v;
    int lat;
    logic ovf_on;

    initial begin
`ifdef ADD_SERIAL_OVF_EN
        ovf_on = 1'b1;
`else
        ovf_on = 1'b0;
`endif
        rst = 1'b1;
        drive(0, 1'b0, 0, 0, 1'b0);
        drive(1, 1'b0, 0, 0, 1'b0);
        ordy8 = 1'b1; ordy16 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready", 32'(rdy8), 32'd1);
        check("rst out_valid", 32'(ov8), 32'd0);
        check("rst out", 32'(out8), 32'd0);
        rst = 1'b0;

        op(0, 32'h35, 32'h4A, 1'b0, r, c, v, lat);
        check("35+4A out", r, 32'h7F);
        check("35+4A carry", 32'(c), 32'd0);
        check("35+4A ovf", 32'(v), 32'd0);
        check("8/1 latency", 32'(lat), 32'd8);

        op(0, 32'hFF, 32'h01, 1'b0, r, c, v, lat);
        check("FF+01 out", r, 32'h00);
        check("FF+01 carry", 32'(c), 32'd1);
        check("FF+01 ovf", 32'(v), 32'd0);

        op(0, 32'h10, 32'h20, 1'b1, r, c, v, lat);
        check("10-20 out", r, 32'hF0);
        check("10-20 carry", 32'(c), 32'd0);

        op(0, 32'h80, 32'h01, 1'b1, r, c, v, lat);
        check("80-01 out", r, 32'h7F);
        check("80-01 carry", 32'(c), 32'd1);
        check("80-01 ovf", 32'(v), 32'(ovf_on));

        op(1, 32'h7FFF, 32'h0001, 1'b0, r, c, v, lat);
        check("7FFF+1 out", r, 32'h8000);
        check("7FFF+1 carry", 32'(c), 32'd0);
        check("7FFF+1 ovf", 32'(v), 32'(ovf_on));
        check("16/4 latency", 32'(lat), 32'd4);

        op(1, 32'h1234, 32'h4321, 1'b1, r, c, v, lat);
        check("1234-4321 out", r, 32'hCF13);
        check("1234-4321 carry", 32'(c), 32'd0);
        op(1, 32'h8000, 32'h0001, 1'b1, r, c, v, lat);
        check("8000-1 out", r, 32'h7FFF);
        check("8000-1 ovf", 32'(v), 32'(ovf_on));
        op(1, 32'hFFFF, 32'hFFFF, 1'b0, r, c, v, lat);
        check("FFFF+FFFF out", r, 32'hFFFE);
        check("FFFF+FFFF carry", 32'(c), 32'd1);

        // Backpressure: result must hold while new operands are offered.
        ordy8 = 1'b0;
        op(0, 32'h12, 32'h34, 1'b0, r, c, v, lat);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1'b1, 32'h99, 32'h11, 1'b0);
            @(posedge clk); #1;
            check("bp out_valid", 32'(ov8), 32'd1);
            check("bp out", 32'(out8), 32'h46);
            check("bp in_ready", 32'(rdy8), 32'd0);
        end
        drive(0, 1'b0, 32'h99, 32'h11, 1'b0);
        ordy8 = 1'b1;
        @(posedge clk); #1;
        check("release in_ready", 32'(rdy8), 32'd1);
        check("release out hold", 32'(out8), 32'h46);
        op(0, 32'h99, 32'h11, 1'b0, r, c, v, lat);
        check("99+11 out", r, 32'hAA);

        // Reset during the third ADD cycle.
        @(posedge clk); #1;
        drive(0, 1'b1, 32'h55, 32'h0F, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 32'h55, 32'h0F, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("midrst out_valid", 32'(ov8), 32'd0);
        check("midrst out", 32'(out8), 32'd0);
        check("midrst in_ready", 32'(rdy8), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        op(0, 32'h01, 32'h02, 1'b0, r, c, v, lat);
        check("01+02 out", r, 32'h03);
        check("post-rst latency", 32'(lat), 32'd8);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
